// File: rtl/logic_avalon_st_to_axi4_stream_top.sv
// Avalon-ST source to AXI4-Stream sink bridge with a credit-managed skid buffer and packet framing.
// Latency: a beat presented in cycle t appears on tx_* in cycle t+1 (buffer head is registered state).
// Backpressure: rx_ready is credit based (occupancy + grants still in flight < DEPTH); tx_tready only drains the buffer.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   rx_*                  Avalon-ST sink side (valid, sop, eop, channel, error, empty, data, ready)
//   rx_protocol_error     single-cycle pulse for an ungranted beat, an orphan beat or a SOP inside a packet
//   tx_*                  AXI4-Stream master side (tvalid, tlast, tdata, tkeep, tstrb, tdest, tuser, tid, tready)
module logic_avalon_st_to_axi4_stream_top #(
  parameter int TDATA_BYTES   = 4,
  parameter int TDEST_WIDTH   = 1,
  parameter int TUSER_WIDTH   = 1,
  parameter int TID_WIDTH     = 1,
  parameter int ERROR_WIDTH   = 1,
  parameter int EMPTY_WIDTH   = (TDATA_BYTES < 2) ? 1 : $clog2(TDATA_BYTES),
  parameter int READY_LATENCY = 0
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     rx_valid,
  input  logic                     rx_startofpacket,
  input  logic                     rx_endofpacket,
  input  logic [TID_WIDTH-1:0]     rx_channel,
  input  logic [ERROR_WIDTH-1:0]   rx_error,
  input  logic [EMPTY_WIDTH-1:0]   rx_empty,
  input  logic [TDATA_BYTES*8-1:0] rx_data,
  output logic                     rx_ready,
  output logic                     rx_protocol_error,
  output logic                     tx_tvalid,
  output logic                     tx_tlast,
  output logic [TDATA_BYTES*8-1:0] tx_tdata,
  output logic [TDATA_BYTES-1:0]   tx_tkeep,
  output logic [TDATA_BYTES-1:0]   tx_tstrb,
  output logic [TDEST_WIDTH-1:0]   tx_tdest,
  output logic [TUSER_WIDTH-1:0]   tx_tuser,
  output logic [TID_WIDTH-1:0]     tx_tid,
  input  logic                     tx_tready
);

  localparam int DEPTH = READY_LATENCY + 2;
  localparam int PW    = $clog2(DEPTH);
  // Wide enough for count (<= 10) plus in-flight grants (<= 8).
  localparam int CW    = 5;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  localparam logic [0:0] S_IDLE      = 1'b0;
  localparam logic [0:0] S_IN_PACKET = 1'b1;

  typedef struct packed {
    logic                     last;
    logic [TDATA_BYTES-1:0]   keep;
    logic [TDATA_BYTES*8-1:0] data;
    logic [TID_WIDTH-1:0]     tid;
    logic [TUSER_WIDTH-1:0]   user;
  } beat_t;

  logic [0:0]    state;
  beat_t         mem [DEPTH];
  beat_t         wr_beat;
  beat_t         head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] pending;
  logic          granted;
  logic          beat;
  logic          wr_en;
  logic          rd_en;

  logic [TDATA_BYTES*8-1:0] wr_data;
  logic [TDATA_BYTES-1:0]   wr_keep;
  logic [31:0]              empty_clamp;
  logic [31:0]              kept;

  // Only registered state feeds rx_ready, so there is no combinational path from tx_tready or rx_valid.
  assign rx_ready = !areset && ((count + pending) < DEPTH_C);

  generate
    if (READY_LATENCY == 0) begin : g_no_latency
      assign granted = rx_ready;
      assign pending = '0;
    end else begin : g_latency
      // Bit 0 holds the grant from one cycle ago, the MSB the grant from READY_LATENCY cycles ago.
      logic [READY_LATENCY-1:0] grant_hist;

      always_ff @(posedge aclk) begin
        if (areset) begin
          grant_hist <= '0;
        end else begin
          grant_hist <= (grant_hist << 1) | READY_LATENCY'(rx_ready);
        end
      end

      assign granted = grant_hist[READY_LATENCY-1];

      always_comb begin
        pending = '0;
        for (int i = 0; i < READY_LATENCY; i++) begin
          pending = pending + CW'(grant_hist[i]);
        end
      end
    end
  endgenerate

  assign beat  = !areset && rx_valid && granted;
  // In IDLE only a SOP beat opens a packet; anything else is discarded.
  assign wr_en = beat && ((state == S_IN_PACKET) || rx_startofpacket);
  assign rd_en = tx_tvalid && tx_tready;

  assign rx_protocol_error = !areset && rx_valid &&
                             (!granted || ((state == S_IDLE) ? !rx_startofpacket : rx_startofpacket));

  // Avalon symbol 0 sits in the top byte; AXI byte 0 sits in the bottom byte.
  generate
    for (genvar i = 0; i < TDATA_BYTES; i++) begin : g_swap
      assign wr_data[i*8 +: 8] = rx_data[(TDATA_BYTES-1-i)*8 +: 8];
    end
  endgenerate

  // Empty is clamped so an EOP beat always keeps at least byte 0.
  always_comb begin
    wr_keep     = '0;
    empty_clamp = 32'(rx_empty);
    if (empty_clamp > 32'(TDATA_BYTES - 1)) begin
      empty_clamp = 32'(TDATA_BYTES - 1);
    end
    kept = 32'(TDATA_BYTES) - empty_clamp;
    for (int i = 0; i < TDATA_BYTES; i++) begin
      wr_keep[i] = !rx_endofpacket || (32'(i) < kept);
    end
  end

  assign wr_beat = {rx_endofpacket, wr_keep, wr_data, rx_channel, TUSER_WIDTH'(rx_error)};

  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (beat) begin
        if (state == S_IDLE) begin
          if (rx_startofpacket && !rx_endofpacket) begin
            state <= S_IN_PACKET;
          end
        end else if (rx_endofpacket) begin
          state <= S_IDLE;
        end
      end
      if (wr_en) begin
        mem[wr_ptr] <= wr_beat;
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  assign head      = mem[rd_ptr];
  assign tx_tvalid = (count != '0);
  assign tx_tlast  = head.last;
  assign tx_tdata  = head.data;
  assign tx_tkeep  = head.keep;
  assign tx_tstrb  = head.keep;
  assign tx_tid    = head.tid;
  assign tx_tuser  = head.user;
  assign tx_tdest  = '0;

endmodule
